wb_arbiter_tag_nx1: RTL and testbench
=====================================

// Module: wb_arbiter_tag_Nx1
// PURPOSE
//  Round-robin arbiter sharing one tagged Wishbone initiator port among N_INITIATORS requesters.
//  Sits upstream of wb_interconnect_tag_1xN: its i_ port drives that interconnect's t_ port.
//  Grant is held for a whole bus cycle (t_cyc high), which preserves locked and burst sequences.
//  A watchdog terminates stalled cycles with an error.
// PARAMETERS
//  ADR_WIDTH     32   address width
//  DAT_WIDTH     32   data width; sel width is DAT_WIDTH/8
//  TGA_WIDTH     4    address-tag width
//  TGD_WIDTH     4    data-tag width (write and read)
//  TGC_WIDTH     4    cycle-tag width
//  N_INITIATORS  2    number of requesters, >=1
//  TIMEOUT       256  stalled-beat limit in cycles; 0 disables the watchdog
// PORTS
//  clock    in   1                  system clock
//  reset    in   1                  synchronous, active-high reset
//  t_adr/t_dat_w/t_sel/t_we/t_tga/t_tgd_w/t_tgc  in  N_INITIATORS*field  per-requester request fields
//  t_cyc,t_stb  in   N_INITIATORS   per-requester cycle / strobe
//  t_dat_r  out  DAT_WIDTH          read data, broadcast to all requesters
//  t_tgd_r  out  TGD_WIDTH          read data tag, broadcast
//  t_ack,t_err  out  N_INITIATORS   per-requester termination
//  i_adr/i_dat_w/i_sel/i_we/i_tga/i_tgd_w/i_tgc  out  field  muxed from the granted requester
//  i_cyc,i_stb  out  1              granted requester's cyc/stb, gated by state
//  i_dat_r,i_tgd_r  in  DAT_WIDTH/TGD_WIDTH  read data from downstream
//  i_ack,i_err  in   1              termination from downstream
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, last=N_INITIATORS-1 so requester 0 wins first, wdog=0.
//   i_cyc, i_stb, t_ack and t_err are 0 while reset is high (combinationally gated).
//  States:
//   IDLE: if any t_cyc[k], choose the first requester at or after last+1 (mod N).
//     Register gnt; go to BUSY. Request-to-i_cyc latency is 1 clock.
//   BUSY: i_cyc=t_cyc[gnt] and i_stb=t_stb[gnt]. All i_ data fields mux from gnt.
//     t_ack[gnt]=i_ack, t_err[gnt]=i_err; every other bit of t_ack/t_err is 0.
//     When t_cyc[gnt]==0: i_cyc=0 in that same cycle, then last<=gnt and go to IDLE.
//     Consequence: one idle clock between grants; no requester is starved.
//   ABORT: i_cyc=i_stb=0, t_err[gnt]=1 for exactly 1 clock; then last<=gnt and go to IDLE.
//  Watchdog:
//   In BUSY, wdog increments on each cycle with i_stb & ~i_ack & ~i_err.
//   wdog clears on ack, on err, when stb is low, and in IDLE.
//   When wdog==TIMEOUT-1 and the beat is still unterminated, go to ABORT next clock.
//   Counter width is $clog2(TIMEOUT+1).
//  Unmuxed outputs: i_ data fields follow requester gnt at all times (requester 0 out of reset).
//   Downstream qualifies them with i_cyc.
//  Boundary conditions:
//   - ack/err arriving in the same clock that t_cyc drops is forwarded.
//   - ack/err arriving while in IDLE or ABORT is dropped.
//   - A requester that deasserts t_cyc while in IDLE before being granted is never granted.
//   - N_INITIATORS==1 degenerates to a registered pass-through with a 1-clock grant latency.
//   - Reset asserted mid-cycle forces i_cyc=0 immediately and returns to IDLE.
// STRUCTURE
//  wb_arbiter_tag_defines.svh:
//   - state encodings (IDLE=2'd0, BUSY=2'd1, ABORT=2'd2);
//   - port-list macros extending wishbone_tag_macros.svh with a target-port array form.
//  Sub-module wb_rr_arb_core: combinational rotate-priority select.
//   Inputs: req[N], last index. Outputs: gnt index, valid.
//   The FSM, watchdog and muxes stay in the top module.
// TESTING
//  1. N=2, only t_cyc[0] high, ack after 2 clocks -> i_cyc high 1 clock after request; t_ack[0] once; t_ack[1]=0.
//  2. t_cyc[0] and t_cyc[1] both held continuously, each cycle 1 beat -> grants alternate 0,1,0,1 with 1 idle clock between grants.
//  3. Requester 1 holds cyc for a 4-beat burst while requester 0 requests -> 4 acks to 1 with no interleave; then requester 0 is granted.
//  4. TIMEOUT=8, downstream never acks -> t_err[gnt] pulses exactly once 9 clocks after stb; i_cyc=0 during that clock; returns to IDLE.
//  5. i_err asserted on a beat -> t_err[gnt]=1 same clock, t_ack=0, watchdog cleared.
//  6. Reset asserted while in BUSY -> i_cyc=0 same clock; after reset the next grant goes to requester 0.

Source files
------------

// File: rtl/wb_arbiter_tag_pkg.sv
// Shared types and sizing helpers for the tagged Wishbone N-to-1 round-robin arbiter.
package wb_arbiter_tag_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StAbort = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit index so the port lists stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // TIMEOUT of 0 disables the watchdog; keep a 1-bit counter so declarations stay legal.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_tag_nx1_rr_core.sv
// Combinational rotate-priority selector: picks the first requester after 'last' (mod N).
module wb_arbiter_tag_nx1_rr_core
  import wb_arbiter_tag_pkg::*;
#(
  parameter int unsigned N_INITIATORS = 2,
  localparam int unsigned IdxW = idx_width(N_INITIATORS)
) (
  input  logic [N_INITIATORS-1:0] req,
  input  logic [IdxW-1:0]         last,
  output logic [IdxW-1:0]         gnt,
  output logic                    valid
);

  always_comb begin
    logic [IdxW-1:0] idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    // Offsets 1..N visit last+1 first and last itself only at the very end.
    for (int unsigned i = 1; i <= N_INITIATORS; i++) begin
      idx = IdxW'((32'(last) + i) % N_INITIATORS);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        gnt   = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_tag_nx1.sv
// Round-robin arbiter sharing one tagged Wishbone initiator port among N requesters,
// holding the grant for a whole bus cycle and aborting stalled beats via a watchdog.
module wb_arbiter_tag_nx1
  import wb_arbiter_tag_pkg::*;
#(
  parameter int unsigned ADR_WIDTH    = 32,
  parameter int unsigned DAT_WIDTH    = 32,
  parameter int unsigned TGA_WIDTH    = 4,
  parameter int unsigned TGD_WIDTH    = 4,
  parameter int unsigned TGC_WIDTH    = 4,
  parameter int unsigned N_INITIATORS = 2,
  parameter int unsigned TIMEOUT      = 256,
  localparam int unsigned SelW        = DAT_WIDTH / 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_INITIATORS*ADR_WIDTH-1:0] t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0] t_dat_w,
  input  logic [N_INITIATORS*SelW-1:0]      t_sel,
  input  logic [N_INITIATORS-1:0]           t_we,
  input  logic [N_INITIATORS*TGA_WIDTH-1:0] t_tga,
  input  logic [N_INITIATORS*TGD_WIDTH-1:0] t_tgd_w,
  input  logic [N_INITIATORS*TGC_WIDTH-1:0] t_tgc,
  input  logic [N_INITIATORS-1:0]           t_cyc,
  input  logic [N_INITIATORS-1:0]           t_stb,
  output logic [DAT_WIDTH-1:0]              t_dat_r,
  output logic [TGD_WIDTH-1:0]              t_tgd_r,
  output logic [N_INITIATORS-1:0]           t_ack,
  output logic [N_INITIATORS-1:0]           t_err,
  output logic [ADR_WIDTH-1:0]              i_adr,
  output logic [DAT_WIDTH-1:0]              i_dat_w,
  output logic [SelW-1:0]                   i_sel,
  output logic                              i_we,
  output logic [TGA_WIDTH-1:0]              i_tga,
  output logic [TGD_WIDTH-1:0]              i_tgd_w,
  output logic [TGC_WIDTH-1:0]              i_tgc,
  output logic                              i_cyc,
  output logic                              i_stb,
  input  logic [DAT_WIDTH-1:0]              i_dat_r,
  input  logic [TGD_WIDTH-1:0]              i_tgd_r,
  input  logic                              i_ack,
  input  logic                              i_err
);

  localparam int unsigned IdxW  = idx_width(N_INITIATORS);
  localparam int unsigned WdogW = wdog_width(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  logic [IdxW-1:0]  arb_gnt;
  logic             arb_valid;
  logic             stall;
  logic             wdog_hit;

  wb_arbiter_tag_nx1_rr_core #(
    .N_INITIATORS (N_INITIATORS)
  ) u_rr_core (
    .req   (t_cyc),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Data path follows the registered grant unconditionally; i_cyc qualifies it downstream.
  assign i_adr   = t_adr[gnt_q*ADR_WIDTH +: ADR_WIDTH];
  assign i_dat_w = t_dat_w[gnt_q*DAT_WIDTH +: DAT_WIDTH];
  assign i_sel   = t_sel[gnt_q*SelW +: SelW];
  assign i_we    = t_we[gnt_q];
  assign i_tga   = t_tga[gnt_q*TGA_WIDTH +: TGA_WIDTH];
  assign i_tgd_w = t_tgd_w[gnt_q*TGD_WIDTH +: TGD_WIDTH];
  assign i_tgc   = t_tgc[gnt_q*TGC_WIDTH +: TGC_WIDTH];
  assign t_dat_r = i_dat_r;
  assign t_tgd_r = i_tgd_r;

  assign stall    = i_stb & ~i_ack & ~i_err;
  assign wdog_hit = (TIMEOUT != 0) && (wdog_q == WdogW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_INITIATORS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = '0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!t_cyc[gnt_q]) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end else if (stall) begin
          if (wdog_hit) begin
            state_d = StAbort;
          end else begin
            wdog_d = wdog_q + WdogW'(1);
          end
        end
      end
      StAbort: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gates the bus-facing strobes combinationally so a mid-cycle reset drops i_cyc at once.
  always_comb begin
    i_cyc = 1'b0;
    i_stb = 1'b0;
    t_ack = '0;
    t_err = '0;
    if (!reset) begin
      case (state_q)
        StBusy: begin
          i_cyc        = t_cyc[gnt_q];
          i_stb        = t_stb[gnt_q];
          t_ack[gnt_q] = i_ack;
          t_err[gnt_q] = i_err;
        end
        StAbort: t_err[gnt_q] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_tag_nx1.sv
// Directed bench for the two-requester arbiter with an 8-cycle watchdog.
module tb_wb_arbiter_tag_nx1;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned N  = 2;
  localparam int unsigned SW = DW / 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*AW-1:0] t_adr;
  logic [N*DW-1:0] t_dat_w;
  logic [N*SW-1:0] t_sel;
  logic [N-1:0]    t_we;
  logic [N*TW-1:0] t_tga, t_tgd_w, t_tgc;
  logic [N-1:0]    t_cyc, t_stb;
  logic [DW-1:0]   t_dat_r;
  logic [TW-1:0]   t_tgd_r;
  logic [N-1:0]    t_ack, t_err;
  logic [AW-1:0]   i_adr;
  logic [DW-1:0]   i_dat_w;
  logic [SW-1:0]   i_sel;
  logic            i_we;
  logic [TW-1:0]   i_tga, i_tgd_w, i_tgc;
  logic            i_cyc, i_stb;
  logic [DW-1:0]   i_dat_r;
  logic [TW-1:0]   i_tgd_r;
  logic            i_ack, i_err;

  int total = 0;
  int bad   = 0;
  int exp_g;

  wb_arbiter_tag_nx1 #(
    .ADR_WIDTH    (AW),
    .DAT_WIDTH    (DW),
    .TGA_WIDTH    (TW),
    .TGD_WIDTH    (TW),
    .TGC_WIDTH    (TW),
    .N_INITIATORS (N),
    .TIMEOUT      (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .t_adr   (t_adr),
    .t_dat_w (t_dat_w),
    .t_sel   (t_sel),
    .t_we    (t_we),
    .t_tga   (t_tga),
    .t_tgd_w (t_tgd_w),
    .t_tgc   (t_tgc),
    .t_cyc   (t_cyc),
    .t_stb   (t_stb),
    .t_dat_r (t_dat_r),
    .t_tgd_r (t_tgd_r),
    .t_ack   (t_ack),
    .t_err   (t_err),
    .i_adr   (i_adr),
    .i_dat_w (i_dat_w),
    .i_sel   (i_sel),
    .i_we    (i_we),
    .i_tga   (i_tga),
    .i_tgd_w (i_tgd_w),
    .i_tgc   (i_tgc),
    .i_cyc   (i_cyc),
    .i_stb   (i_stb),
    .i_dat_r (i_dat_r),
    .i_tgd_r (i_tgd_r),
    .i_ack   (i_ack),
    .i_err   (i_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset   = 1'b1;
    t_cyc   = '0;
    t_stb   = '0;
    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_dat_r = 32'hDEAD_BEEF;
    i_tgd_r = 4'h5;
    t_adr   = {32'h2000_0000, 32'h1000_0000};
    t_dat_w = {32'hBBBB_0001, 32'hAAAA_0000};
    t_sel   = {4'hC, 4'h3};
    t_we    = 2'b10;
    t_tga   = {4'h2, 4'h1};
    t_tgd_w = {4'h9, 4'h6};
    t_tgc   = {4'hE, 4'h7};

    // Reset: strobes and terminations gated even with activity on the inputs.
    tick();
    t_cyc = 2'b01; t_stb = 2'b01; i_ack = 1'b1; i_err = 1'b1;
    #1;
    chk("rst_cyc", 64'(i_cyc), 64'(0));
    chk("rst_stb", 64'(i_stb), 64'(0));
    chk("rst_ack", 64'(t_ack), 64'(0));
    chk("rst_err", 64'(t_err), 64'(0));
    tick();
    i_ack = 1'b0; i_err = 1'b0; t_cyc = '0; t_stb = '0; reset = 1'b0;
    #1;
    chk("rst_adr", 64'(i_adr), 64'h1000_0000);
    chk("rst_dat_r", 64'(t_dat_r), 64'hDEAD_BEEF);
    chk("rst_tgd_r", 64'(t_tgd_r), 64'h5);
    chk("rst_idle_cyc", 64'(i_cyc), 64'(0));

    // Single requester, ack two clocks after i_cyc rises.
    t_cyc = 2'b01; t_stb = 2'b01;
    #1;
    chk("t1_latency", 64'(i_cyc), 64'(0));
    tick(); #1;
    chk("t1_cyc", 64'(i_cyc), 64'(1));
    chk("t1_stb", 64'(i_stb), 64'(1));
    chk("t1_we", 64'(i_we), 64'(0));
    chk("t1_noack0", 64'(t_ack), 64'(0));
    tick(); #1;
    chk("t1_noack1", 64'(t_ack), 64'(0));
    tick(); i_ack = 1'b1; #1;
    chk("t1_ack", 64'(t_ack), 64'b01);
    tick(); i_ack = 1'b0; t_cyc = '0; t_stb = '0; #1;
    chk("t1_drop_cyc", 64'(i_cyc), 64'(0));
    chk("t1_drop_ack", 64'(t_ack), 64'(0));
    tick();

    // Both requesters continuously, one beat per bus cycle: grants alternate.
    t_cyc = 2'b11; t_stb = 2'b11;
    exp_g = 1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("t2_idle_cyc", 64'(i_cyc), 64'(0));
      tick(); i_ack = 1'b1; #1;
      chk("t2_cyc", 64'(i_cyc), 64'(1));
      chk("t2_adr", 64'(i_adr), (exp_g == 1) ? 64'h2000_0000 : 64'h1000_0000);
      chk("t2_ack", 64'(t_ack), 64'(1) << exp_g);
      tick(); i_ack = 1'b0; t_cyc[exp_g] = 1'b0; t_stb[exp_g] = 1'b0; #1;
      chk("t2_drop_cyc", 64'(i_cyc), 64'(0));
      tick(); t_cyc = 2'b11; t_stb = 2'b11;
      exp_g = 1 - exp_g;
    end

    // Requester 1 bursts four beats while requester 0 waits.
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      i_ack = 1'b1; #1;
      chk("t3_cyc", 64'(i_cyc), 64'(1));
      chk("t3_ack", 64'(t_ack), 64'b10);
    end
    chk("t3_dat_w", 64'(i_dat_w), 64'hBBBB_0001);
    chk("t3_sel", 64'(i_sel), 64'hC);
    chk("t3_we", 64'(i_we), 64'(1));
    chk("t3_tga", 64'(i_tga), 64'h2);
    chk("t3_tgd_w", 64'(i_tgd_w), 64'h9);
    chk("t3_tgc", 64'(i_tgc), 64'hE);
    tick(); i_ack = 1'b0; t_cyc = 2'b01; t_stb = 2'b01; #1;
    chk("t3_drop_cyc", 64'(i_cyc), 64'(0));
    tick(); #1;
    chk("t3_idle_cyc", 64'(i_cyc), 64'(0));
    tick(); #1;
    chk("t3_gnt0_cyc", 64'(i_cyc), 64'(1));
    chk("t3_gnt0_adr", 64'(i_adr), 64'h1000_0000);

    // Error on a stalled beat is forwarded and clears the watchdog.
    tick(); #1;
    tick(); i_err = 1'b1; #1;
    chk("t5_err", 64'(t_err), 64'b01);
    chk("t5_ack", 64'(t_ack), 64'(0));
    tick(); i_err = 1'b0;

    // Eight stalled beats from a cleared watchdog, then a one-clock abort.
    for (int a = 0; a < 8; a++) begin
      if (a != 0) tick();
      #1;
      chk("t4_stall_cyc", 64'(i_cyc), 64'(1));
      chk("t4_stall_err", 64'(t_err), 64'(0));
    end
    tick(); i_ack = 1'b1; #1;
    chk("t4_abort_err", 64'(t_err), 64'b01);
    chk("t4_abort_cyc", 64'(i_cyc), 64'(0));
    chk("t4_abort_stb", 64'(i_stb), 64'(0));
    chk("t4_abort_ack", 64'(t_ack), 64'(0));
    tick(); i_ack = 1'b0; t_cyc = 2'b11; t_stb = 2'b11; #1;
    chk("t4_idle_err", 64'(t_err), 64'(0));
    chk("t4_idle_cyc", 64'(i_cyc), 64'(0));

    // Reset during a grant to requester 1; afterwards requester 0 wins.
    tick(); #1;
    chk("t6_busy_cyc", 64'(i_cyc), 64'(1));
    chk("t6_busy_adr", 64'(i_adr), 64'h2000_0000);
    reset = 1'b1; i_ack = 1'b1; #1;
    chk("t6_rst_cyc", 64'(i_cyc), 64'(0));
    chk("t6_rst_ack", 64'(t_ack), 64'(0));
    tick();
    tick(); reset = 1'b0; i_ack = 1'b0; #1;
    chk("t6_idle_cyc", 64'(i_cyc), 64'(0));
    tick(); #1;
    chk("t6_gnt_cyc", 64'(i_cyc), 64'(1));
    chk("t6_gnt_adr", 64'(i_adr), 64'h1000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
